// File: rtl/multi_ball_physics_pkg.sv
// rtl/multi_ball_physics_pkg.sv - shared ball state type, edge bit indices, FSM states, saturation helper
package multi_ball_physics_pkg;

  typedef struct packed {
    logic signed [31:0] posX;
    logic signed [31:0] posY;
    logic signed [31:0] vx;
    logic signed [31:0] vy;
  } ball_state_t;

  // Bit positions inside a 4-bit {L,T,R,B} edge code
  localparam int EDGE_L = 3;
  localparam int EDGE_T = 2;
  localparam int EDGE_R = 1;
  localparam int EDGE_B = 0;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} fsm_t;

  // Clamp v to [-lim, lim]
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int lim);
    logic signed [31:0] l;
    l = lim;
    if (v > l) return l;
    if (v < -l) return -l;
    return v;
  endfunction

endpackage

// File: rtl/multi_ball_physics_if.sv
// rtl/multi_ball_physics_if.sv - frame/collision/launch inputs and per-ball position outputs of the ball engine
// Ports (master drives the engine, slave is the engine):
//   startOfFrame, pause, resetLevel    frame control
//   collisionValid, hitEdgeCode        per-ball collision strobes and {L,T,R,B} codes
//   launchValid, launchIdx, launchSpeedX/Y   velocity load into one ball
//   topLeftX/Y, ballActive, ballLost   per-ball outputs (11-bit slots)
//   busy, frameDone, overrunError      engine status
interface multi_ball_physics_if #(parameter int N_BALLS = 4);
  localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;

  logic                   startOfFrame;
  logic                   pause;
  logic                   resetLevel;
  logic [N_BALLS-1:0]     collisionValid;
  logic [4*N_BALLS-1:0]   hitEdgeCode;
  logic                   launchValid;
  logic [IW-1:0]          launchIdx;
  logic signed [31:0]     launchSpeedX;
  logic signed [31:0]     launchSpeedY;
  logic [11*N_BALLS-1:0]  topLeftX;
  logic [11*N_BALLS-1:0]  topLeftY;
  logic [N_BALLS-1:0]     ballActive;
  logic [N_BALLS-1:0]     ballLost;
  logic                   busy;
  logic                   frameDone;
  logic                   overrunError;

  modport master (
    output startOfFrame, pause, resetLevel, collisionValid, hitEdgeCode,
           launchValid, launchIdx, launchSpeedX, launchSpeedY,
    input  topLeftX, topLeftY, ballActive, ballLost, busy, frameDone, overrunError
  );

  modport slave (
    input  startOfFrame, pause, resetLevel, collisionValid, hitEdgeCode,
           launchValid, launchIdx, launchSpeedX, launchSpeedY,
    output topLeftX, topLeftY, ballActive, ballLost, busy, frameDone, overrunError
  );

endinterface

// File: rtl/multi_ball_physics_ball_step.sv
// rtl/multi_ball_physics_ball_step.sv - combinational one-frame step for a single ball
// Ports:
//   cur    in   current ball state (fixed point)
//   edges  in   latched {L,T,R,B} collision mask for this ball
//   nxt    out  state after reflect, damp, saturate, integrate, gravity
module multi_ball_physics_ball_step
  import multi_ball_physics_pkg::*;
#(
  parameter int GRAVITY    = 2,
  parameter int MAX_SPEED  = 1024,
  parameter int DAMP_SHIFT = 0
) (
  input  ball_state_t cur,
  input  logic [3:0]  edges,
  output ball_state_t nxt
);

  logic signed [31:0] vx;
  logic signed [31:0] vy;

  always_comb begin
    vx = cur.vx;
    vy = cur.vy;
    // Only reflect a component that is moving into the wall it hit
    if ((edges[EDGE_L] && cur.vx < 0) || (edges[EDGE_R] && cur.vx > 0)) begin
      vx = -cur.vx;
      if (DAMP_SHIFT > 0) vx = vx - (vx >>> DAMP_SHIFT);
    end
    if ((edges[EDGE_T] && cur.vy < 0) || (edges[EDGE_B] && cur.vy > 0)) begin
      vy = -cur.vy;
      if (DAMP_SHIFT > 0) vy = vy - (vy >>> DAMP_SHIFT);
    end
    vx = sat(vx, MAX_SPEED);
    vy = sat(vy, MAX_SPEED);
    nxt.posX = cur.posX + vx;
    nxt.posY = cur.posY + vy;
    nxt.vx   = vx;
    // Gravity is applied after integration, so it affects the next frame's motion
    nxt.vy   = sat(vy + GRAVITY, MAX_SPEED);
  end

endmodule

// File: rtl/multi_ball_physics.sv
// rtl/multi_ball_physics.sv - time-multiplexed multi-ball kinematics engine
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   bus    slave side of multi_ball_physics_if (frame control, collisions,
//          launches in; per-ball pixel positions, activity, lost/frame events out)
module multi_ball_physics
  import multi_ball_physics_pkg::*;
#(
  parameter int N_BALLS    = 4,
  parameter int FRAC_BITS  = 6,
  parameter int GRAVITY    = 2,
  parameter int MAX_SPEED  = 1024,
  parameter int DAMP_SHIFT = 0,
  parameter int INIT_X     = 300,
  parameter int INIT_Y     = 100,
  parameter int SPACING_X  = 20,
  parameter int LOST_Y     = 470,
  parameter logic [N_BALLS-1:0] INIT_ACTIVE = 'b1
) (
  input logic clk,
  input logic reset,
  multi_ball_physics_if.slave bus
);

  localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BALLS - 1);

  function automatic ball_state_t init_ball(input int i);
    ball_state_t b;
    b.posX = (INIT_X + i * SPACING_X) << FRAC_BITS;
    b.posY = INIT_Y << FRAC_BITS;
    b.vx   = '0;
    b.vy   = '0;
    return b;
  endfunction

  function automatic logic [10:0] to_px(input logic signed [31:0] p);
    return 11'(p >>> FRAC_BITS);
  endfunction

  fsm_t                  fsm_q, fsm_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  overrun_set;
  logic                  overrun_q;
  logic                  clr;
  logic                  stepping;
  ball_state_t           state_q [N_BALLS];
  logic [3:0]            mask_q  [N_BALLS];
  logic [N_BALLS-1:0]    active_q;
  logic [N_BALLS-1:0]    lost_q;
  logic [11*N_BALLS-1:0] tlx_q;
  logic [11*N_BALLS-1:0] tly_q;
  ball_state_t           step_nxt;
  logic signed [31:0]    new_py_px;

  assign clr       = reset || bus.resetLevel;
  assign stepping  = (fsm_q == UPDATE) && !bus.pause;
  assign new_py_px = step_nxt.posY >>> FRAC_BITS;

  multi_ball_physics_ball_step #(
    .GRAVITY    (GRAVITY),
    .MAX_SPEED  (MAX_SPEED),
    .DAMP_SHIFT (DAMP_SHIFT)
  ) u_step (
    .cur   (state_q[idx_q]),
    .edges (mask_q[idx_q]),
    .nxt   (step_nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      fsm_q <= IDLE;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    overrun_set = 1'b0;
    if (!bus.pause) begin
      case (fsm_q)
        IDLE: begin
          if (bus.startOfFrame) begin
            fsm_d = UPDATE;
            idx_d = '0;
          end
        end
        UPDATE: begin
          overrun_set = bus.startOfFrame;
          if (idx_q == LAST_IDX) fsm_d = DONE;
          else                   idx_d = idx_q + 1'b1;
        end
        DONE: begin
          overrun_set = bus.startOfFrame;
          fsm_d       = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  // Sticky: only a full reset clears it, a level restart keeps the evidence
  always_ff @(posedge clk) begin
    if (reset)                                overrun_q <= 1'b0;
    else if (!bus.resetLevel && overrun_set)  overrun_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_BALLS; i++) begin
        state_q[i]          <= init_ball(i);
        mask_q[i]           <= '0;
        tlx_q[11*i +: 11]   <= 11'(INIT_X + i * SPACING_X);
        tly_q[11*i +: 11]   <= 11'(INIT_Y);
      end
      active_q <= INIT_ACTIVE;
      lost_q   <= '0;
    end else begin
      lost_q <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        tlx_q[11*i +: 11] <= to_px(state_q[i].posX);
        tly_q[11*i +: 11] <= to_px(state_q[i].posY);
        if (bus.collisionValid[i])
          mask_q[i] <= mask_q[i] | bus.hitEdgeCode[4*i +: 4];
      end
      if (stepping) begin
        // Consume this ball's mask; a same-cycle collision belongs to the next frame
        mask_q[idx_q] <= bus.collisionValid[idx_q] ? bus.hitEdgeCode[4*int'(idx_q) +: 4] : 4'b0;
        if (active_q[idx_q]) begin
          state_q[idx_q] <= step_nxt;
          if (new_py_px > LOST_Y) begin
            active_q[idx_q] <= 1'b0;
            lost_q[idx_q]   <= 1'b1;
          end
        end
      end
      // Placed after the step so a coinciding launch wins the velocity fields
      if (bus.launchValid && !bus.pause) begin
        state_q[bus.launchIdx].vx <= bus.launchSpeedX;
        state_q[bus.launchIdx].vy <= bus.launchSpeedY;
        active_q[bus.launchIdx]   <= 1'b1;
      end
    end
  end

  assign bus.topLeftX     = tlx_q;
  assign bus.topLeftY     = tly_q;
  assign bus.ballActive   = active_q;
  assign bus.ballLost     = lost_q;
  assign bus.busy         = (fsm_q != IDLE);
  assign bus.frameDone    = (fsm_q == DONE) && !bus.pause && !clr;
  assign bus.overrunError = overrun_q;

endmodule

// File: tb/tb_multi_ball_physics.sv
// tb/tb_multi_ball_physics.sv - directed self-checking bench for multi_ball_physics
module tb_multi_ball_physics;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_ball_physics_if #(.N_BALLS(N)) bus ();
  multi_ball_physics_if #(.N_BALLS(N)) bus_d ();

  multi_ball_physics #(.N_BALLS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  multi_ball_physics #(.N_BALLS(N), .DAMP_SHIFT(2)) dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d.slave)
  );

  assign bus_d.startOfFrame   = bus.startOfFrame;
  assign bus_d.pause          = bus.pause;
  assign bus_d.resetLevel     = bus.resetLevel;
  assign bus_d.collisionValid = bus.collisionValid;
  assign bus_d.hitEdgeCode    = bus.hitEdgeCode;
  assign bus_d.launchValid    = bus.launchValid;
  assign bus_d.launchIdx      = bus.launchIdx;
  assign bus_d.launchSpeedX   = bus.launchSpeedX;
  assign bus_d.launchSpeedY   = bus.launchSpeedY;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt, lat, lost_cyc;
  logic [N-1:0] lost_seen, any_lost;
  int exp_vy [3] = '{2, 4, 6};
  int exp_py [3] = '{6400, 6402, 6406};

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [11*N-1:0] v, input int i);
    return int'(v[11*i +: 11]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect frameDone / ballLost activity over a bounded window
  task automatic watch(input int cycles, input int lat_base);
    fd_cnt = 0; lat = 0; lost_seen = '0; lost_cyc = 0;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      if (bus.frameDone) begin
        fd_cnt++;
        if (lat == 0) lat = k + lat_base;
      end
      lost_seen = lost_seen | bus.ballLost;
      lost_cyc += $countones(bus.ballLost);
    end
  endtask

  task automatic run_frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    watch(10, 1);
  endtask

  task automatic launch(input int idx, input int sx, input int sy);
    bus.launchValid  = 1'b1;
    bus.launchIdx    = 2'(idx);
    bus.launchSpeedX = sx;
    bus.launchSpeedY = sy;
    tick();
    bus.launchValid  = 1'b0;
  endtask

  task automatic collide(input int idx, input logic [3:0] code);
    bus.collisionValid = '0;
    bus.hitEdgeCode    = '0;
    bus.collisionValid[idx] = 1'b1;
    bus.hitEdgeCode[4*idx +: 4] = code;
    tick();
    bus.collisionValid = '0;
    bus.hitEdgeCode    = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.pause = 1'b0; bus.resetLevel = 1'b0;
    bus.collisionValid = '0; bus.hitEdgeCode = '0;
    bus.launchValid = 1'b0; bus.launchIdx = '0;
    bus.launchSpeedX = 0; bus.launchSpeedY = 0;
    tick(); tick();
    reset = 1'b0;

    check_eq("rst_busy",   bus.busy, 0);
    check_eq("rst_active", bus.ballActive, 4'b0001);
    check_eq("rst_x1",     slot(bus.topLeftX, 1), 320);
    check_eq("rst_y0",     slot(bus.topLeftY, 0), 100);
    check_eq("rst_ovr",    bus.overrunError, 0);
    check_eq("rst_vy0",    $signed(dut.state_q[0].vy), 0);

    // Free fall of ball 0
    for (int f = 0; f < 3; f++) begin
      run_frame();
      check_eq("ff_done", fd_cnt, 1);
      if (f == 0) check_eq("ff_latency", lat, 5);
      check_eq("ff_vy",   $signed(dut.state_q[0].vy), exp_vy[f]);
      check_eq("ff_posy", $signed(dut.state_q[0].posY), exp_py[f]);
      check_eq("ff_tly",  slot(bus.topLeftY, 0), 100);
    end

    // Ball 1 launched downward, bottom collision reflects it
    launch(1, 0, 128);
    check_eq("l1_active", bus.ballActive, 4'b0011);
    collide(1, 4'b0001);
    run_frame();
    check_eq("b1_vy",      $signed(dut.state_q[1].vy), -126);
    check_eq("b1_posy",    $signed(dut.state_q[1].posY), 6272);
    check_eq("b1_tly",     slot(bus.topLeftY, 1), 98);
    check_eq("b1d_vy",     $signed(dut_d.state_q[1].vy), -94);
    check_eq("b1d_posy",   $signed(dut_d.state_q[1].posY), 6304);
    check_eq("b0_vy",      $signed(dut.state_q[0].vy), 8);
    check_eq("b0_posy",    $signed(dut.state_q[0].posY), 6412);
    run_frame();
    check_eq("b1_mask_vy",   $signed(dut.state_q[1].vy), -124);
    check_eq("b1_mask_posy", $signed(dut.state_q[1].posY), 6146);

    // X speed saturation
    launch(2, 2000, 0);
    check_eq("l2_vx_raw", $signed(dut.state_q[2].vx), 2000);
    run_frame();
    check_eq("sat_vx",  $signed(dut.state_q[2].vx), 1024);
    check_eq("sat_tlx", slot(bus.topLeftX, 2), 356);
    check_eq("sat_vy",  $signed(dut.state_q[2].vy), 2);

    // startOfFrame during pause is ignored without an overrun
    bus.pause = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
    check_eq("pause_busy", bus.busy, 0);
    check_eq("pause_ovr",  bus.overrunError, 0);
    bus.pause = 1'b0;

    // Overrun: second startOfFrame two cycles after the first
    bus.startOfFrame = 1'b1; tick();
    bus.startOfFrame = 1'b0; tick();
    bus.startOfFrame = 1'b1; tick();
    bus.startOfFrame = 1'b0;
    watch(10, 3);
    check_eq("ovr_flag", bus.overrunError, 1);
    check_eq("ovr_done", fd_cnt, 1);

    // resetLevel in the middle of a frame
    bus.startOfFrame = 1'b1; tick();
    bus.startOfFrame = 1'b0; tick(); tick();
    check_eq("rl_idx", dut.idx_q, 2);
    bus.resetLevel = 1'b1; tick();
    bus.resetLevel = 1'b0;
    check_eq("rl_busy",   bus.busy, 0);
    check_eq("rl_x0",     slot(bus.topLeftX, 0), 300);
    check_eq("rl_x2",     slot(bus.topLeftX, 2), 340);
    check_eq("rl_y3",     slot(bus.topLeftY, 3), 100);
    check_eq("rl_active", bus.ballActive, 4'b0001);
    check_eq("rl_ovr",    bus.overrunError, 1);
    check_eq("rl_vy1",    $signed(dut.state_q[1].vy), 0);
    watch(8, 0);
    check_eq("rl_no_done", fd_cnt, 0);

    // Drive ball 3 to posY = (470<<6)-10 with per-frame launches
    any_lost = '0;
    for (int k = 0; k < 24; k++) begin
      launch(3, 0, (k < 23) ? 1024 : 118);
      run_frame();
      any_lost = any_lost | lost_seen;
    end
    check_eq("lost_pre_posy",   $signed(dut.state_q[3].posY), 30070);
    check_eq("lost_pre_tly",    slot(bus.topLeftY, 3), 469);
    check_eq("lost_pre_active", bus.ballActive, 4'b1001);
    check_eq("lost_pre_none",   any_lost, 0);
    launch(3, 0, 64);
    run_frame();
    check_eq("lost_470_posy", $signed(dut.state_q[3].posY), 30134);
    check_eq("lost_470_vy",   $signed(dut.state_q[3].vy), 66);
    check_eq("lost_470_none", lost_seen, 0);
    run_frame();
    check_eq("lost_pulse",  lost_seen, 4'b1000);
    check_eq("lost_cycles", lost_cyc, 1);
    check_eq("lost_active", bus.ballActive, 4'b0001);
    check_eq("lost_posy",   $signed(dut.state_q[3].posY), 30200);
    run_frame();
    check_eq("frozen_posy", $signed(dut.state_q[3].posY), 30200);
    check_eq("frozen_tly",  slot(bus.topLeftY, 3), 471);
    check_eq("frozen_none", lost_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
